// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - register file write-port owner: post-reset clear, round-robin writeback arbiter, RAW hazard flags
module rf_write_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              A_VALID,
    output logic              A_READY,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [DATA_W-1:0] A_DATA,
    input  logic              B_VALID,
    output logic              B_READY,
    input  logic [ADDR_W-1:0] B_ADDR,
    input  logic [DATA_W-1:0] B_DATA,
    input  logic [ADDR_W-1:0] RD_ADDR1,
    input  logic [ADDR_W-1:0] RD_ADDR2,
    output logic              HAZARD1,
    output logic              HAZARD2,
    output logic              WR_EN,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [DATA_W-1:0] WR_DATA,
    output logic              BUSY
);

    // Counter must reach NUM_REGS itself, which marks the end of the clear pass.
    localparam int CNT_W = $clog2(NUM_REGS + 1);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [CNT_W-1:0]    clr_cnt;
    logic [CNT_W-1:0]    clr_cnt_nx;
    logic                last_b;
    logic                last_b_nx;
    logic                wr_en_nx;
    logic [ADDR_W-1:0]   wr_addr_nx;
    logic [DATA_W-1:0]   wr_data_nx;
    logic                grant_a;
    logic                grant_b;

    // Round-robin grant: a lone requester always wins, contention goes to whoever did not win last.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == RUN) begin
            grant_a = A_VALID && (!B_VALID || last_b);
            grant_b = B_VALID && (!A_VALID || !last_b);
        end
    end

    assign A_READY = grant_a;
    assign B_READY = grant_b;
    assign BUSY    = (state == CLEAR);

    // A read of x0 never hazards because x0 is hardwired and never written.
    assign HAZARD1 = WR_EN && (WR_ADDR == RD_ADDR1) && (RD_ADDR1 != '0);
    assign HAZARD2 = WR_EN && (WR_ADDR == RD_ADDR2) && (RD_ADDR2 != '0);

    // Next-state and output-stage load: clear walk in CLEAR, winner capture in RUN.
    always_comb begin
        state_nx   = state;
        clr_cnt_nx = clr_cnt;
        last_b_nx  = last_b;
        wr_en_nx   = 1'b0;
        wr_addr_nx = WR_ADDR;
        wr_data_nx = WR_DATA;
        case (state)
            CLEAR: begin
                if (clr_cnt == CNT_W'(NUM_REGS)) begin
                    state_nx = RUN;
                end else begin
                    wr_en_nx   = 1'b1;
                    wr_addr_nx = ADDR_W'(clr_cnt);
                    wr_data_nx = '0;
                    clr_cnt_nx = clr_cnt + CNT_W'(1);
                end
            end
            RUN: begin
                // Writes to x0 are accepted but never reach the register file.
                if (grant_a) begin
                    wr_en_nx   = (A_ADDR != '0);
                    wr_addr_nx = A_ADDR;
                    wr_data_nx = A_DATA;
                    last_b_nx  = 1'b0;
                end else if (grant_b) begin
                    wr_en_nx   = (B_ADDR != '0);
                    wr_addr_nx = B_ADDR;
                    wr_data_nx = B_DATA;
                    last_b_nx  = 1'b1;
                end
            end
            default: state_nx = CLEAR;
        endcase
    end

    // State, clear counter, fairness bit and registered write port; reset restarts the clear pass.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= CLEAR;
            clr_cnt <= CNT_W'(1);
            last_b  <= 1'b1;
            WR_EN   <= 1'b0;
            WR_ADDR <= '0;
            WR_DATA <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= clr_cnt_nx;
            last_b  <= last_b_nx;
            WR_EN   <= wr_en_nx;
            WR_ADDR <= wr_addr_nx;
            WR_DATA <= wr_data_nx;
        end
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
Owns the single write port of the 32x32 OTTER register file. After reset it runs a clear sequence that zeroes x1..x31 through the write port. It then shares the port between two writeback requesters, A (ALU/CSR writeback) and B (load return), using valid/ready handshakes and round-robin arbitration. It also flags read-after-write hazards for the two asynchronous read ports.

Parameters:
ADDR_W, 5, register address width
DATA_W, 32, register data width
NUM_REGS, 32, number of registers; the clear sequence covers 1..NUM_REGS-1

Ports:
CLK  input  1  clock; all state updates on posedge
RST  input  1  asynchronous, active-high reset
A_VALID  input  1  requester A has a write pending
A_READY  output  1  requester A accepted this cycle
A_ADDR  input  ADDR_W  requester A destination register
A_DATA  input  DATA_W  requester A write data
B_VALID  input  1  requester B has a write pending
B_READY  output  1  requester B accepted this cycle
B_ADDR  input  ADDR_W  requester B destination register
B_DATA  input  DATA_W  requester B write data
RD_ADDR1  input  ADDR_W  register file read address 1
RD_ADDR2  input  ADDR_W  register file read address 2
HAZARD1  output  1  in-flight write targets RD_ADDR1
HAZARD2  output  1  in-flight write targets RD_ADDR2
WR_EN  output  1  register file write enable (registered)
WR_ADDR  output  ADDR_W  register file write address (registered)
WR_DATA  output  DATA_W  register file write data (registered)
BUSY  output  1  clear sequence in progress

Behaviour:
- Reset (RST=1, asynchronous):
  - state=CLEAR, clear counter=1, WR_EN=0, WR_ADDR=0, WR_DATA=0, BUSY=1.
  - last_grant=B, so A wins the first contention.
  - A_READY=B_READY=0.
  - Assertion mid-operation aborts any in-flight write (WR_EN drops immediately) and restarts CLEAR.
- CLEAR state:
  - Edge k after reset release (k=1..NUM_REGS-1): WR_EN=1, WR_ADDR=k, WR_DATA=0.
  - Edge NUM_REGS: WR_EN=0, state=RUN, BUSY=0.
  - Both READY outputs stay 0 throughout; VALIDs are ignored.
- RUN state, combinational grant:
  - Only A_VALID: grant A.
  - Only B_VALID: grant B.
  - Both valid: grant the requester not equal to last_grant.
  - A_READY = RUN and grant==A; B_READY = RUN and grant==B. At most one READY is high per cycle.
- Transfer:
  - A transfer occurs on an edge where VALID and READY are both high.
  - On the transfer edge, the output stage loads WR_ADDR and WR_DATA from the winner. last_grant is set to the winner.
  - WR_EN=1 if the winner's ADDR!=0. If ADDR==0, WR_EN=0: the request is accepted and dropped.
  - Latency: request accepted at edge n is presented on WR_* after edge n and committed by the register file at edge n+1.
  - With no transfer on an edge, WR_EN=0 after that edge; WR_ADDR and WR_DATA hold their values.
- Requester rule:
  - VALID, ADDR and DATA hold stable until the READY cycle.
  - A requester held off by contention is served on the next edge if it is still valid. Worst-case wait is 1 cycle.
- Hazard:
  - HAZARDn = WR_EN and (WR_ADDR==RD_ADDRn) and (RD_ADDRn!=0). This is combinational and the same in CLEAR and RUN.
- Throughput: one write per cycle sustained; back-to-back writes from the same requester are allowed.

Test Plan:
- Reset release, no requests -> WR_EN=1 for 31 consecutive cycles with WR_ADDR 1..31 and WR_DATA=0; BUSY falls on edge 32; READYs 0 throughout.
- RUN, A_VALID alone with A_ADDR=5, A_DATA=0xDEADBEEF -> A_READY=1 same cycle; next cycle WR_EN=1, WR_ADDR=5, WR_DATA=0xDEADBEEF; then WR_EN=0.
- Both valid for 4 cycles (A_ADDR=3, B_ADDR=7), first contention after reset -> grant order A,B,A,B; WR_ADDR sequence 3,7,3,7.
- B_VALID with B_ADDR=0, B_DATA=0x1234 -> B_READY=1; next cycle WR_EN=0.
- Write to x9 in flight with RD_ADDR1=9, RD_ADDR2=0 -> HAZARD1=1, HAZARD2=0.
- Write to x0 in flight (WR_ADDR=0) with RD_ADDR1=0 -> HAZARD1=0.
- RST asserted while WR_EN=1 (mid-RUN) -> WR_EN=0 immediately; BUSY=1; the clear sequence restarts at address 1 after release.
